// File: rtl/ads_frame_packetizer.sv
// ads_frame_packetizer: captures ADC lane frames into a two-entry ping-pong
// buffer and streams them as a sequence-numbered byte-wide AXI-stream payload.
module ads_frame_packetizer #(
  parameter int LANE_COUNT        = 8,
  parameter int BITS_PER_PACKET   = 24,
  parameter int FRAMES_PER_PACKET = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  enable,
  input  logic [LANE_COUNT-1:0]                 lane_mask,
  input  logic [LANE_COUNT*BITS_PER_PACKET-1:0] frame_data,
  input  logic                                  frame_valid,
  output logic [7:0]                            m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic                                  busy,
  output logic [15:0]                           overflow_count,
  output logic [15:0]                           packet_seq
);

  localparam int FW  = LANE_COUNT * BITS_PER_PACKET;
  localparam int BPL = BITS_PER_PACKET / 8;
  localparam int LW  = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;
  localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam logic [7:0]    LAST_FRAME = 8'(FRAMES_PER_PACKET - 1);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(BPL - 1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WAIT} state_t;

  // lowest enabled lane strictly above cur (cur = -1 gives the first lane)
  function automatic logic [LW-1:0] next_lane(
    input logic [LANE_COUNT-1:0] m,
    input int                    cur
  );
    logic [LW-1:0] r;
    logic          f;
    r = '0;
    f = 1'b0;
    for (int i = 0; i < LANE_COUNT; i++) begin
      if (!f && i > cur && m[i]) begin
        r = LW'(i);
        f = 1'b1;
      end
    end
    return r;
  endfunction

  // no enabled lane above cur
  function automatic logic tail_lane(
    input logic [LANE_COUNT-1:0] m,
    input int                    cur
  );
    logic t;
    t = 1'b1;
    for (int i = 0; i < LANE_COUNT; i++) begin
      if (i > cur && m[i]) t = 1'b0;
    end
    return t;
  endfunction

  // byte b (0 = MSB) of a lane sample
  function automatic logic [7:0] pick(
    input logic [FW-1:0] f,
    input int            lane,
    input int            b
  );
    return f[lane*BITS_PER_PACKET + BITS_PER_PACKET - 8 - 8*b +: 8];
  endfunction

  state_t                state;
  logic [FW-1:0]         mem [2];
  logic [1:0]            count;
  logic [1:0]            count_rel;
  logic                  wr_slot;
  logic                  rd_slot;
  logic [LANE_COUNT-1:0] active_mask;
  logic [7:0]            frame_idx;
  logic [LW-1:0]         cur_lane;
  logic [BW-1:0]         cur_byte;
  logic [LW-1:0]         first_lane;
  logic [LW-1:0]         nxt_lane;
  logic [BW-1:0]         nxt_byte;
  logic                  first_end;
  logic                  frame_end;
  logic                  nxt_end;
  logic                  hs;
  logic                  rel;
  logic                  cap;
  logic                  drop;

  assign hs         = m_axis_tvalid & m_axis_tready;
  assign first_lane = next_lane(active_mask, -1);
  assign first_end  = (LAST_BYTE == '0) &&
                      tail_lane(active_mask, int'(first_lane));
  assign frame_end  = (cur_byte == LAST_BYTE) &&
                      tail_lane(active_mask, int'(cur_lane));
  assign nxt_lane   = (cur_byte == LAST_BYTE) ?
                      next_lane(active_mask, int'(cur_lane)) : cur_lane;
  assign nxt_byte   = (cur_byte == LAST_BYTE) ? '0 : cur_byte + 1'b1;
  assign nxt_end    = (nxt_byte == LAST_BYTE) &&
                      tail_lane(active_mask, int'(nxt_lane));
  assign rel        = (state == DATA) & hs & frame_end;
  assign count_rel  = count - {1'b0, rel};
  assign cap        = frame_valid & (enable | busy) & (count_rel != 2'd2);
  assign drop       = frame_valid & (enable | busy) & ~cap;

  // occupancy, slot pointers and dropped-frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count          <= '0;
      wr_slot        <= 1'b0;
      rd_slot        <= 1'b0;
      overflow_count <= '0;
    end else begin
      count <= count_rel + {1'b0, cap};
      if (cap) wr_slot <= ~wr_slot;
      if (rel) rd_slot <= ~rd_slot;
      if (drop && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 16'd1;
    end
  end

  // frame storage; contents are don't-care while the slot is free
  always_ff @(posedge clk) begin
    if (cap) mem[wr_slot] <= frame_data;
  end

  // packet sequencer with registered stream outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      active_mask   <= '0;
      frame_idx     <= '0;
      cur_lane      <= '0;
      cur_byte      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      packet_seq    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count != 2'd0) begin
            state       <= HDR0;
            active_mask <= (lane_mask == '0) ? '1 : lane_mask;
            frame_idx   <= '0;
            busy        <= 1'b1;
          end
        end
        HDR0: begin
          if (!m_axis_tvalid) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= packet_seq[15:8];
          end else if (m_axis_tready) begin
            state        <= HDR1;
            m_axis_tdata <= packet_seq[7:0];
          end
        end
        HDR1: begin
          if (hs) begin
            state        <= DATA;
            cur_lane     <= first_lane;
            cur_byte     <= '0;
            m_axis_tdata <= pick(mem[rd_slot], int'(first_lane), 0);
            m_axis_tlast <= first_end && (frame_idx == LAST_FRAME);
          end
        end
        DATA: begin
          if (hs) begin
            if (frame_end) begin
              if (frame_idx == LAST_FRAME) begin
                state         <= IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                busy          <= 1'b0;
                packet_seq    <= packet_seq + 16'd1;
              end else begin
                frame_idx <= frame_idx + 8'd1;
                cur_lane  <= first_lane;
                cur_byte  <= '0;
                if (count == 2'd2) begin
                  m_axis_tdata <= pick(mem[~rd_slot], int'(first_lane), 0);
                  m_axis_tlast <= first_end &&
                                  (frame_idx + 8'd1 == LAST_FRAME);
                end else begin
                  state         <= WAIT;
                  m_axis_tvalid <= 1'b0;
                  m_axis_tlast  <= 1'b0;
                end
              end
            end else begin
              cur_lane     <= nxt_lane;
              cur_byte     <= nxt_byte;
              m_axis_tdata <= pick(mem[rd_slot], int'(nxt_lane),
                                   int'(nxt_byte));
              m_axis_tlast <= nxt_end && (frame_idx == LAST_FRAME);
            end
          end
        end
        WAIT: begin
          if (count != 2'd0) begin
            state         <= DATA;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= pick(mem[rd_slot], int'(first_lane), 0);
            m_axis_tlast  <= first_end && (frame_idx == LAST_FRAME);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ads_frame_packetizer.sv
// tb_ads_frame_packetizer: directed plus randomized stimulus against a
// byte-stream reference model of the packet format.
module tb_ads_frame_packetizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         enable;
  logic [7:0]   lane_mask;
  logic [191:0] frame_data;
  logic         fv0, fv1;
  logic         tready0, tready1;
  logic [7:0]   tdata0, tdata1;
  logic         tvalid0, tvalid1;
  logic         tlast0, tlast1;
  logic         busy0, busy1;
  logic [15:0]  ovf0, ovf1;
  logic [15:0]  seq0, seq1;

  ads_frame_packetizer u0 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .lane_mask(lane_mask), .frame_data(frame_data),
    .frame_valid(fv0), .m_axis_tdata(tdata0),
    .m_axis_tvalid(tvalid0), .m_axis_tready(tready0),
    .m_axis_tlast(tlast0), .busy(busy0),
    .overflow_count(ovf0), .packet_seq(seq0)
  );

  ads_frame_packetizer #(.FRAMES_PER_PACKET(1)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .lane_mask(lane_mask), .frame_data(frame_data),
    .frame_valid(fv1), .m_axis_tdata(tdata1),
    .m_axis_tvalid(tvalid1), .m_axis_tready(tready1),
    .m_axis_tlast(tlast1), .busy(busy1),
    .overflow_count(ovf1), .packet_seq(seq1)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  bit rnd    = 1'b0;

  logic [7:0] rx_q[$];
  bit         rx_last[$];
  logic [7:0] rx1_q[$];
  bit         rx1_last[$];
  logic [7:0] exp_q[$];
  bit         exp_last[$];

  // record every byte that will transfer on the coming rising edge
  always @(negedge clk) begin
    #1;
    if (reset_n && tvalid0 && tready0) begin
      rx_q.push_back(tdata0);
      rx_last.push_back(tlast0);
    end
    if (reset_n && tvalid1 && tready1) begin
      rx1_q.push_back(tdata1);
      rx1_last.push_back(tlast1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd) tready0 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input logic [191:0] d, input bit to1);
    frame_data = d;
    if (to1) fv1 = 1'b1;
    else fv0 = 1'b1;
    tick(1);
    fv0 = 1'b0;
    fv1 = 1'b0;
  endtask

  function automatic void model_header(input logic [15:0] s);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
    exp_last.push_back(1'b0);
    exp_last.push_back(1'b0);
  endfunction

  function automatic void model_frame(input logic [191:0] f,
                                      input logic [7:0] m);
    logic [7:0]  mm;
    logic [23:0] s;
    mm = (m == 8'h00) ? 8'hFF : m;
    for (int l = 0; l < 8; l++) begin
      if (mm[l]) begin
        s = f[l*24 +: 24];
        exp_q.push_back(s[23:16]);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
        repeat (3) exp_last.push_back(1'b0);
      end
    end
  endfunction

  function automatic void model_end();
    exp_last[exp_last.size()-1] = 1'b1;
  endfunction

  function automatic void clear_all();
    rx_q.delete();
    rx_last.delete();
    exp_q.delete();
    exp_last.delete();
  endfunction

  task automatic compare_stream(input string tag);
    int n;
    int c;
    n = exp_q.size();
    c = 0;
    while (rx_q.size() < n && c < 3000) begin
      tick(1);
      c++;
    end
    tick(20);
    chk({tag, "_len"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      chk({tag, "_byte"}, rx_q[i], exp_q[i]);
      chk({tag, "_last"}, rx_last[i], exp_last[i]);
    end
  endtask

  function automatic logic [191:0] rand_frame();
    return {$urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom()};
  endfunction

  logic [191:0] fr;
  logic [191:0] f5 [5];
  logic [7:0]   pm [3];
  logic [7:0]   e1 [8];

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    lane_mask  = 8'hFF;
    frame_data = '0;
    fv0        = 1'b0;
    fv1        = 1'b0;
    tready0    = 1'b1;
    tready1    = 1'b1;
    tick(3);
    chk("rst_tvalid", tvalid0, 0);
    chk("rst_tdata", tdata0, 0);
    chk("rst_tlast", tlast0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_seq", seq0, 0);
    reset_n = 1'b1;
    tick(2);

    // full-mask packet, frames spaced 200 cycles apart
    enable = 1'b1;
    clear_all();
    for (int i = 0; i < 8; i++) fr[i*24 +: 24] = 24'h100000 + 24'(i);
    model_header(16'd0);
    send(fr, 1'b0);
    chk("lat_n0_tvalid", tvalid0, 0);
    tick(1);
    chk("lat_n1_busy", busy0, 1);
    chk("lat_n1_tvalid", tvalid0, 0);
    tick(1);
    chk("lat_n2_tvalid", tvalid0, 1);
    chk("lat_n2_tdata", tdata0, 0);
    model_frame(fr, 8'hFF);
    for (int k = 1; k < 4; k++) begin
      tick(197);
      send(fr, 1'b0);
      model_frame(fr, 8'hFF);
    end
    model_end();
    compare_stream("p1");
    chk("p1_b2", rx_q[2], 8'h10);
    chk("p1_b3", rx_q[3], 8'h00);
    chk("p1_b4", rx_q[4], 8'h00);
    chk("p1_seq", seq0, 1);
    chk("p1_busy", busy0, 0);

    // one-frame packets with sparse mask
    lane_mask = 8'h05;
    fr = {192{1'b1}};
    fr[23:0]  = 24'hA1B2C3;
    fr[71:48] = 24'h0D0E0F;
    e1 = '{8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'h0D, 8'h0E, 8'h0F};
    send(fr, 1'b1);
    tick(40);
    chk("m05_len", rx1_q.size(), 8);
    for (int i = 0; i < 8 && i < rx1_q.size(); i++) begin
      chk("m05_byte", rx1_q[i], e1[i]);
      chk("m05_last", rx1_last[i], (i == 7) ? 1 : 0);
    end
    chk("m05_seq", seq1, 1);

    // stalled sink, five back-to-back frames
    lane_mask = 8'hFF;
    tready0 = 1'b0;
    clear_all();
    for (int k = 0; k < 5; k++) f5[k] = rand_frame();
    for (int k = 0; k < 5; k++) begin
      frame_data = f5[k];
      fv0 = 1'b1;
      tick(1);
    end
    fv0 = 1'b0;
    chk("ovf_3", ovf0, 3);
    chk("stall_tvalid", tvalid0, 1);
    chk("stall_tdata", tdata0, 8'h00);
    tick(6);
    chk("stall_hold_tvalid", tvalid0, 1);
    chk("stall_hold_tdata", tdata0, 8'h00);
    model_header(16'd1);
    model_frame(f5[0], 8'hFF);
    model_frame(f5[1], 8'hFF);
    tready0 = 1'b1;
    tick(80);
    for (int k = 2; k < 4; k++) begin
      fr = rand_frame();
      send(fr, 1'b0);
      model_frame(fr, 8'hFF);
      tick(60);
    end
    model_end();
    compare_stream("stall");
    chk("stall_ovf_keep", ovf0, 3);

    // enable dropped mid-packet
    clear_all();
    model_header(16'd2);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) enable = 1'b0;
      fr = rand_frame();
      send(fr, 1'b0);
      model_frame(fr, 8'hFF);
      tick(60);
    end
    model_end();
    compare_stream("en");
    chk("en_ovf", ovf0, 3);
    send(rand_frame(), 1'b0);
    tick(10);
    chk("en_ign_busy", busy0, 0);
    chk("en_ign_tvalid", tvalid0, 0);
    chk("en_ign_ovf", ovf0, 3);
    chk("en_ign_rx", rx_q.size(), exp_q.size());

    // asynchronous reset in the middle of the data phase
    enable = 1'b1;
    send(rand_frame(), 1'b0);
    tick(10);
    chk("pre_rst_tvalid", tvalid0, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tvalid", tvalid0, 0);
    chk("arst_tdata", tdata0, 0);
    chk("arst_tlast", tlast0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_ovf", ovf0, 0);
    chk("arst_seq", seq0, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    clear_all();

    // three packets under random backpressure and mask churn
    pm[0] = 8'($urandom_range(1, 255));
    pm[1] = 8'h00;
    pm[2] = 8'($urandom_range(0, 255));
    rnd = 1'b1;
    for (int p = 0; p < 3; p++) begin
      lane_mask = pm[p];
      model_header(16'(p));
      for (int k = 0; k < 4; k++) begin
        fr = rand_frame();
        send(fr, 1'b0);
        model_frame(fr, pm[p]);
        if (k == 1) lane_mask = 8'($urandom);
        tick(150);
      end
      model_end();
    end
    rnd = 1'b0;
    tready0 = 1'b1;
    compare_stream("rand");
    chk("rand_seq", seq0, 3);
    chk("rand_ovf", ovf0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
